// File: rtl/inst_ram_responder.sv
// Instruction-fetch responder: word-addressed RAM behind the openmips ROM port,
// with a fixed number of wait states and a side loader used before the core runs.
module inst_ram_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce_i,
   input  logic [31:0]           addr_i,
   output logic [31:0]           inst_o,
   output logic                  valid_o,
   output logic                  stall_o,
   output logic                  err_o,
   input  logic                  ld_we_i,
   input  logic [DEPTH_LOG2-1:0] ld_addr_i,
   input  logic [31:0]           ld_data_i,
   output logic                  ld_drop_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   logic                    mis_q, mis_d;
   logic [31:0]             inst_q;
   logic                    valid_q, err_q, drop_q;
   logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

   logic [DEPTH_LOG2-1:0]   addr_idx, rd_idx;
   logic                    addr_mis, rd_mis, accept, ld_ok, resp_load;
   logic                    unused_addr_hi;

   assign addr_idx       = addr_i[DEPTH_LOG2+1:2];
   assign addr_mis       = |addr_i[1:0];
   assign unused_addr_hi = ^addr_i[31:DEPTH_LOG2+2];
   assign accept         = (state_q == S_IDLE) && ce_i;
   assign ld_ok          = (state_q == S_IDLE) && !ce_i;
   // With zero wait states the read happens on the accept edge itself,
   // so the index comes straight from the address bus in that case.
   assign rd_idx         = accept ? addr_idx : idx_q;
   assign rd_mis         = accept ? addr_mis : mis_q;
   assign resp_load      = (state_d == S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      mis_d   = mis_q;
      case (state_q)
         S_IDLE: if (ce_i) begin
            idx_d   = addr_idx;
            mis_d   = addr_mis;
            cnt_d   = WAIT_INIT;
            state_d = (WAIT_INIT != 4'd0) ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (!ce_i)              state_d = S_IDLE;
            else if (cnt_q <= 4'd1) state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall_o = 1'b0;
      if (!rst) stall_o = accept || (state_q == S_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         valid_q <= resp_load;
         err_q   <= resp_load && rd_mis;
         if (resp_load) inst_q <= rd_mis ? 32'h0 : mem[rd_idx];
         if (ld_we_i && !ld_ok) drop_q <= 1'b1;
      end
   end

   // RAM contents survive reset, so the array has no reset term.
   always_ff @(posedge clk) begin
      if (ld_we_i && ld_ok) mem[ld_addr_i] <= ld_data_i;
   end

   assign inst_o    = inst_q;
   assign valid_o   = valid_q;
   assign err_o     = err_q;
   assign ld_drop_o = drop_q;

endmodule

// File: tb/tb_inst_ram_responder.sv
// Bench for inst_ram_responder: three instances (0, 1 and 3 wait states) driven
// one at a time; expected responses go to a queue checked by a monitor.
module tb_inst_ram_responder;

   localparam int NI = 3;

   logic        clk, rst;
   logic        ce      [NI];
   logic [31:0] addr    [NI];
   logic [31:0] inst    [NI];
   logic        valid   [NI];
   logic        stall   [NI];
   logic        err     [NI];
   logic        ld_we   [NI];
   logic [9:0]  ld_addr [NI];
   logic [31:0] ld_data [NI];
   logic        drop    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      inst_ram_responder #(
         .DEPTH_LOG2 (10),
         .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 3)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .ce_i     (ce[g]),
         .addr_i   (addr[g]),
         .inst_o   (inst[g]),
         .valid_o  (valid[g]),
         .stall_o  (stall[g]),
         .err_o    (err[g]),
         .ld_we_i  (ld_we[g]),
         .ld_addr_i(ld_addr[g]),
         .ld_data_i(ld_data[g]),
         .ld_drop_o(drop[g])
      );
   end

   typedef struct {
      int          g;
      logic [31:0] d;
      logic        e;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [NI][1024];
   logic [31:0] last_inst [NI];
   int          cyc = 0, npass = 0, ntot = 0, nval = 0, npush = 0;

   function automatic int wc(int g);
      return (g == 0) ? 0 : (g == 1) ? 1 : 3;
   endfunction

   function automatic void chk(string n, logic [31:0] got, logic [31:0] want);
      ntot++;
      if (got === want) npass++;
      else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", n, got, want, cyc);
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         if (valid[g]) begin
            exp_t e;
            nval++;
            if (q.size() == 0) chk("spurious_valid", 32'(valid[g]), 32'h0);
            else begin
               e = q.pop_front();
               chk("resp_lane",  g,           e.g);
               chk("resp_inst",  inst[g],     e.d);
               chk("resp_err",   32'(err[g]), 32'(e.e));
               chk("resp_cycle", cyc,         e.due);
               last_inst[g] = e.d;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(int g, int idx, logic [31:0] d);
      ld_we[g] = 1'b1; ld_addr[g] = 10'(idx); ld_data[g] = d;
      tick();
      ld_we[g] = 1'b0;
      mdl[g][idx] = d;
   endtask

   // Called in an IDLE cycle; returns in the IDLE cycle after RESP with ce still high.
   task automatic fetch(int g, logic [31:0] a);
      exp_t e;
      int   n;
      ce[g] = 1'b1; addr[g] = a;
      e.g   = g;
      e.e   = (a % 4) != 0;
      e.d   = e.e ? 32'h0 : mdl[g][(a / 4) % 1024];
      e.due = cyc + 1 + wc(g);
      q.push_back(e);
      npush++;
      #1;
      n = 0;
      for (int k = 0; k < 40 && stall[g]; k++) begin
         n++;
         tick();
      end
      chk("stall_len", n, wc(g) + 1);
      tick();
   endtask

   initial begin
      logic [31:0] plan [4];
      plan[0] = 32'h34010001; plan[1] = 32'h34020002;
      plan[2] = 32'h00221820; plan[3] = 32'hAC030000;
      rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
         ce[g] = 1'b1; addr[g] = 32'h0; ld_we[g] = 1'b0; ld_addr[g] = '0; ld_data[g] = '0;
         last_inst[g] = '0;
      end
      #1 rst = 1'b1;
      tick(); tick();
      for (int g = 0; g < NI; g++) begin
         chk("rst_stall", 32'(stall[g]), 0);
         chk("rst_inst",  inst[g],       0);
         chk("rst_valid", 32'(valid[g]), 0);
         chk("rst_err",   32'(err[g]),   0);
         chk("rst_drop",  32'(drop[g]),  0);
         ce[g] = 1'b0;
      end
      tick();
      rst = 1'b0;
      tick();

      for (int g = 0; g < NI; g++) begin
         for (int i = 0; i < 16; i++) load(g, i, $urandom);
         for (int i = 0; i < 4; i++)  load(g, i, plan[i]);
         chk("preload_nodrop", 32'(drop[g]), 0);
      end

      // program fetch, 1 wait state
      for (int i = 0; i < 4; i++) fetch(1, 32'(i * 4));
      ce[1] = 1'b0; tick();

      // back-to-back, 0 wait states
      for (int i = 0; i < 8; i++) fetch(0, 32'(i * 4));
      ce[0] = 1'b0; tick();

      // misaligned, then check RAM untouched; wrap
      fetch(1, 32'h00000006);
      fetch(1, 32'h00000004);
      fetch(1, 32'h00001004);
      ce[1] = 1'b0; tick();

      // loader write during WAIT is dropped
      begin
         exp_t e;
         ce[1] = 1'b1; addr[1] = 32'h8;
         e.g = 1; e.e = 1'b0; e.d = mdl[1][2]; e.due = cyc + 2;
         q.push_back(e); npush++;
         tick();
         ld_we[1] = 1'b1; ld_addr[1] = 10'd2; ld_data[1] = ~mdl[1][2];
         tick();
         ld_we[1] = 1'b0; ce[1] = 1'b0;
         #1 chk("drop_set", 32'(drop[1]), 1);
         tick(); tick(); tick();
         chk("drop_sticky", 32'(drop[1]), 1);
         fetch(1, 32'h8);
         ce[1] = 1'b0; tick();
      end

      // abort by dropping ce in WAIT, 3 wait states
      fetch(2, 32'h0);
      ce[2] = 1'b0; tick();
      ce[2] = 1'b1; addr[2] = 32'h4;
      tick();
      ce[2] = 1'b0;
      #1 chk("abort_wait_stall", 32'(stall[2]), 1);
      tick();
      chk("abort_idle_stall", 32'(stall[2]), 0);
      repeat (6) tick();
      chk("abort_inst_hold", inst[2], last_inst[2]);
      fetch(2, 32'h4);
      ce[2] = 1'b0; tick();

      // random traffic
      for (int r = 0; r < 60; r++) begin
         int g   = $urandom_range(0, NI - 1);
         int idx = $urandom_range(0, 15);
         if ($urandom_range(0, 9) < 3) load(g, idx, $urandom);
         else begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'(idx * 4);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            fetch(g, a);
            ce[g] = 1'b0;
            tick();
         end
      end

      // reset asserted in WAIT, 3 wait states
      ce[2] = 1'b1; addr[2] = 32'h8;
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("rstw_stall", 32'(stall[2]), 0);
      chk("rstw_inst",  inst[2],       0);
      chk("rstw_valid", 32'(valid[2]), 0);
      chk("rstw_err",   32'(err[2]),   0);
      chk("rstw_drop1", 32'(drop[1]),  0);
      ce[2] = 1'b0;
      tick(); tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("post_rst_stall", 32'(stall[2]), 0);
      chk("post_rst_inst",  inst[2],       0);
      fetch(2, 32'h8);
      fetch(2, 32'hC);
      ce[2] = 1'b0;
      repeat (6) tick();

      chk("queue_empty", q.size(), 0);
      chk("valid_count", nval, npush);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/inst_ram_responder.md
# inst_ram_responder

Instruction-memory responder for the openmips fetch port. It serves the core's `rom_ce_o`/`rom_addr_o` requests from an internal word-addressed RAM with a programmable number of wait states. It drives the fetched word back on the core's `rom_data_i` side and asserts a stall while the access is in flight. A side load port fills the RAM before the core is released; the block replaces the zero-latency ROM in the minimal SOPC when slower, writable instruction storage is needed.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 1: wait states inserted between request accept and response; legal range 0..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `ce_i` input 1: fetch enable, driven from the core's `rom_ce_o`.
- `addr_i` input 32: byte address of the fetch, driven from the core's `rom_addr_o`.
- `inst_o` output 32: fetched instruction, driven to the core's `rom_data_i`.
- `valid_o` output 1: one-cycle pulse marking `inst_o` as the response to the accepted request.
- `stall_o` output 1: request the core hold PC/IF while the fetch is in flight.
- `err_o` output 1: misaligned-fetch flag, valid with `valid_o`.
- `ld_we_i` input 1: loader write strobe.
- `ld_addr_i` input DEPTH_LOG2: loader word index.
- `ld_data_i` input 32: loader write data.
- `ld_drop_o` output 1: sticky flag; a loader write was discarded.

## Operation
- Word index is `addr_i[DEPTH_LOG2+1:2]`. Higher address bits are ignored, so addresses wrap modulo the RAM size.
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE with `ce_i`=1 accepts the request:
  - latches the word index and the misalign bit (`addr_i[1:0]`≠0);
  - loads the wait counter with WAIT_CYCLES;
  - goes to WAIT if WAIT_CYCLES>0, else to RESP.
- WAIT decrements the counter each cycle and goes to RESP when the counter reaches 1.
- RESP registers `inst_o` ← RAM[latched index], or 0x00000000 (nop) if misaligned. `valid_o`=1 and `err_o`=misalign bit for exactly this cycle. The next state is always IDLE.
- `stall_o` is combinational: 1 in IDLE when `ce_i`=1, and 1 in WAIT. It is 0 in RESP, and forced 0 while `rst`=1.
- `inst_o` holds its last value between responses.
- Dropping `ce_i` in WAIT aborts the access: the next state is IDLE, no `valid_o` pulse is issued, and `inst_o` is unchanged.
- The core must hold `addr_i` stable while `stall_o`=1. Changes to `addr_i` after accept are ignored.
- Loader writes:
  - accepted only when the state is IDLE and `ce_i`=0; RAM[`ld_addr_i`] ← `ld_data_i` at the edge;
  - a write presented in any other cycle is discarded and sets `ld_drop_o`;
  - `ld_drop_o` clears only on reset.
- Reset:
  - state → IDLE; `inst_o`=0, `valid_o`=0, `err_o`=0, `ld_drop_o`=0, wait counter 0;
  - RAM contents are not cleared;
  - reset asserted mid-fetch abandons the access with no response.

## Timing
- Request accepted at edge N in IDLE. RESP occupies cycle N+1+WAIT_CYCLES. `inst_o`/`valid_o` are valid in that cycle, and the core samples them at the edge that ends it.
- Throughput is one fetch per WAIT_CYCLES+2 cycles: RESP → IDLE → accept.
- `stall_o` is high for WAIT_CYCLES+1 consecutive cycles per fetch: the accept cycle plus the WAIT cycles.
- A loader write becomes visible to a fetch accepted on the next cycle or later.
- RAM read is synchronous; there is no combinational path from `addr_i` to `inst_o`.
- The only combinational outputs are `stall_o` from `ce_i` and the state.

## Test plan
- Preload RAM[0..3] = 0x34010001, 0x34020002, 0x00221820, 0xAC030000 via the loader with `ce_i`=0. Fetch 0x0, 0x4, 0x8, 0xC with WAIT_CYCLES=1. Required:
  - each word returns 3 cycles after accept;
  - `stall_o` high for 2 cycles per fetch;
  - `valid_o` pulses 4 times;
  - `err_o`=0.
- WAIT_CYCLES=0, back-to-back fetches from 0x0 to 0x1C. Required: a response every 2 cycles, in address order, and `stall_o` high 1 cycle each.
- Fetch at 0x00000006. Required: `inst_o`=0x00000000, `err_o`=1 with `valid_o`, and RAM unchanged.
- DEPTH_LOG2=10, fetch at 0x00001004. Required: returns RAM[1] (wrap).
- Issue `ld_we_i` during WAIT. Required: `ld_drop_o`=1 and stays set, and a subsequent fetch of that index returns the old word.
- With WAIT_CYCLES=3, assert `rst` in WAIT, and separately drop `ce_i` in WAIT. Required in both cases:
  - no `valid_o` pulse;
  - state back to IDLE;
  - `stall_o`=0.
  - After `rst` only, all outputs read 0.
